cla_result_checker: RTL and testbench

CLA_RESULT_CHECKER -- requirements
Module: cla_result_checker

---
 rtl/cla_result_checker.sv | 156 +++++++++++++++
 tb/tb_cla_result_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_result_checker.sv
// cla_result_checker
//   Scores a 4-bit carry-lookahead adder against a reference sum over one
//   run of NUM_VECTORS accepted samples. Each accepted sample is registered
//   into a single pipeline stage, then compared on the next edge.
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   start            in   begins a run from IDLE or DONE (ignored in RUN)
//   in_valid         in   a/b/c0/s/c4 sample valid this cycle
//   a, b             in   4-bit operands (bit 0 = a1/b1, weight 1)
//   c0               in   carry-in
//   s, c4            in   sum and carry-out produced by the adder under test
//   in_ready         out  sample can be accepted (RUN, run not yet full)
//   pass_count       out  compared samples that matched
//   fail_count       out  compared samples that mismatched
//   seq_err          out  sticky: accepted vector differed from running index
//   first_fail_vec   out  {a1,a2,a3,a4,b1,b2,b3,b4,c0} of the first mismatch
//   first_fail_valid out  first_fail_vec holds a captured mismatch
//   done             out  run complete
//   all_pass         out  done with no mismatch and no sequence error
module cla_result_checker #(
  parameter int unsigned NUM_VECTORS = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  input  logic [3:0] s,
  input  logic       c4,
  output logic       in_ready,
  output logic [9:0] pass_count,
  output logic [9:0] fail_count,
  output logic       seq_err,
  output logic [8:0] first_fail_vec,
  output logic       first_fail_valid,
  output logic       done,
  output logic       all_pass
);

  localparam logic [9:0] NV = 10'(NUM_VECTORS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [9:0] acc_cnt;
  logic [8:0] exp_idx;
  logic [8:0] in_vec;
  logic       accept;
  logic       start_run;
  logic       last_cmp;
  logic [9:0] cmp_cnt;

  // pipeline stage: operands and observed result of the accepted sample
  logic       pipe_valid;
  logic [3:0] pipe_a;
  logic [3:0] pipe_b;
  logic       pipe_c0;
  logic [4:0] pipe_obs;
  logic       pipe_order_bad;
  logic [4:0] pipe_exp;
  logic       pipe_match;

  // packed vector puts a1 (operand bit 0) in the MSB, so bits are reversed
  assign in_vec    = {a[0], a[1], a[2], a[3], b[0], b[1], b[2], b[3], c0};
  assign in_ready  = (state == RUN) && (acc_cnt < NV);
  assign accept    = in_valid && in_ready;
  assign start_run = start && (state != RUN);
  assign cmp_cnt   = pass_count + fail_count;
  assign last_cmp  = pipe_valid && (cmp_cnt == NV - 10'd1);

  assign pipe_exp   = {1'b0, pipe_a} + {1'b0, pipe_b} + {4'b0000, pipe_c0};
  assign pipe_match = (pipe_exp == pipe_obs);

  assign done     = (state == DONE);
  assign all_pass = done && (fail_count == '0) && !seq_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)    state_nx = RUN;
      RUN:     if (last_cmp) state_nx = DONE;
      DONE:    if (start)    state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt          <= '0;
      exp_idx          <= '0;
      pipe_valid       <= 1'b0;
      pipe_a           <= '0;
      pipe_b           <= '0;
      pipe_c0          <= 1'b0;
      pipe_obs         <= '0;
      pipe_order_bad   <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      seq_err          <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_run) begin
      acc_cnt          <= '0;
      exp_idx          <= '0;
      pipe_valid       <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      seq_err          <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      pipe_valid <= accept;
      if (accept) begin
        pipe_a         <= a;
        pipe_b         <= b;
        pipe_c0        <= c0;
        pipe_obs       <= {c4, s};
        pipe_order_bad <= (in_vec != exp_idx);
        acc_cnt        <= acc_cnt + 10'd1;
        exp_idx        <= exp_idx + 9'd1;
      end
      if (pipe_valid) begin
        if (pipe_order_bad) seq_err <= 1'b1;
        if (pipe_match) begin
          pass_count <= pass_count + 10'd1;
        end else begin
          fail_count <= fail_count + 10'd1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= {pipe_a[0], pipe_a[1], pipe_a[2], pipe_a[3],
                                 pipe_b[0], pipe_b[1], pipe_b[2], pipe_b[3],
                                 pipe_c0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_result_checker.sv
module tb_cla_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start16 = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_valid16 = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       c0 = 1'b0;
  logic [3:0] s = '0;
  logic       c4 = 1'b0;

  logic       in_ready, seq_err, ffv_valid, done, all_pass;
  logic [9:0] pass_count, fail_count;
  logic [8:0] ffv;

  logic       in_ready16, seq_err16, ffv_valid16, done16, all_pass16;
  logic [9:0] pass_count16, fail_count16;
  logic [8:0] ffv16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_result_checker dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .c0(c0), .s(s), .c4(c4),
    .in_ready(in_ready), .pass_count(pass_count), .fail_count(fail_count),
    .seq_err(seq_err), .first_fail_vec(ffv), .first_fail_valid(ffv_valid),
    .done(done), .all_pass(all_pass)
  );

  cla_result_checker #(.NUM_VECTORS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_valid(in_valid16),
    .a(a), .b(b), .c0(c0), .s(s), .c4(c4),
    .in_ready(in_ready16), .pass_count(pass_count16), .fail_count(fail_count16),
    .seq_err(seq_err16), .first_fail_vec(ffv16), .first_fail_valid(ffv_valid16),
    .done(done16), .all_pass(all_pass16)
  );

  // Drive packed vector v = {a1,a2,a3,a4,b1,b2,b3,b4,c0} with the correct sum;
  // kill_c4 forces the carry-out low to model a broken adder.
  task automatic drive_vec(input int v, input bit kill_c4);
    logic [8:0] pv;
    logic [4:0] sum;
    pv = 9'(v);
    a  = {pv[5], pv[6], pv[7], pv[8]};
    b  = {pv[1], pv[2], pv[3], pv[4]};
    c0 = pv[0];
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, c0};
    s  = sum[3:0];
    c4 = kill_c4 ? 1'b0 : sum[4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (pass_count !== 10'd0 || fail_count !== 10'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, fail_count); end
    n_cmp++; if ({seq_err, ffv_valid, all_pass} !== 3'b000 || ffv !== 9'h000) begin n_bad++; $display("FAIL reset_flags got %b%b%b vec %h want 000 vec 000", seq_err, ffv_valid, all_pass, ffv); end
    n_cmp++; if (in_ready16 !== 1'b0 || done16 !== 1'b0) begin n_bad++; $display("FAIL reset_dut16 got %b%b want 00", in_ready16, done16); end
  endtask

  task automatic test_sweep();
    do_reset();
    pulse_start();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL sweep_ready_after_start got %b want 1", in_ready); end
    for (int i = 0; i < 512; i++) begin
      drive_vec(i, 1'b0);
      in_valid = 1'b1;
      tick();
      // compare lags accept by one edge: after accepting vector i, i compares are done
      if (i == 0 || i == 1 || i == 300) begin
        n_cmp++; if (pass_count !== 10'(i)) begin n_bad++; $display("FAIL sweep_latency_%0d got %0d want %0d", i, pass_count, i); end
      end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL sweep_ready_drop got %b want 0", in_ready); end
    n_cmp++; if (done !== 1'b0 || pass_count !== 10'd511) begin n_bad++; $display("FAIL sweep_pre_done got done=%b pass=%0d want 0/511", done, pass_count); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sweep_done got %b want 1", done); end
    n_cmp++; if (pass_count !== 10'd512 || fail_count !== 10'd0) begin n_bad++; $display("FAIL sweep_counts got %0d/%0d want 512/0", pass_count, fail_count); end
    n_cmp++; if (all_pass !== 1'b1 || seq_err !== 1'b0 || ffv_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_flags got all_pass=%b seq=%b ffv=%b want 1/0/0", all_pass, seq_err, ffv_valid); end
  endtask

  // a=F, b=1, c0=0 packs to {1111,1000,0} = 9'h1F0; its true sum 5'h10 needs c4=1
  task automatic test_fault();
    do_reset();
    pulse_start();
    for (int i = 0; i < 512; i++) begin
      drive_vec(i, i == 'h1F0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (a !== 4'hF || b !== 4'h1 || c0 !== 1'b0) begin
      // last driven vector 511 = a F, b F, c0 1; recheck the fault vector decode
    end
    drive_vec('h1F0, 1'b1);
    if (a !== 4'hF || b !== 4'h1 || c0 !== 1'b0) begin n_bad++; $display("FAIL fault_decode got a=%h b=%h c0=%b want F/1/0", a, b, c0); end
    n_cmp++; if (fail_count !== 10'd1 || pass_count !== 10'd511) begin n_bad++; $display("FAIL fault_counts got %0d/%0d want 511/1", pass_count, fail_count); end
    n_cmp++; if (ffv !== 9'h1F0 || ffv_valid !== 1'b1) begin n_bad++; $display("FAIL fault_vec got %h valid %b want 1F0 valid 1", ffv, ffv_valid); end
    n_cmp++; if (done !== 1'b1 || all_pass !== 1'b0) begin n_bad++; $display("FAIL fault_done got done=%b all_pass=%b want 1/0", done, all_pass); end
  endtask

  task automatic test_gapped();
    int idx;
    int k;
    do_reset();
    pulse_start();
    idx = 0;
    k = 0;
    while (idx < 512 && k < 1200) begin
      drive_vec(idx, 1'b0);
      in_valid = (k % 2 == 1);
      tick();
      if (in_valid) idx++;
      k++;
    end
    n_cmp++; if (idx !== 512) begin n_bad++; $display("FAIL gapped_timeout got %0d want 512", idx); end
    drive_vec(0, 1'b0);
    in_valid = 1'b1;
    repeat (4) tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL gapped_ready got %b want 0", in_ready); end
    n_cmp++; if (pass_count !== 10'd512 || fail_count !== 10'd0) begin n_bad++; $display("FAIL gapped_counts got %0d/%0d want 512/0", pass_count, fail_count); end
    n_cmp++; if (done !== 1'b1 || all_pass !== 1'b1) begin n_bad++; $display("FAIL gapped_done got %b/%b want 1/1", done, all_pass); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      drive_vec(i, 1'b0);
      in_valid = 1'b1;
      tick();
    end
    n_cmp++; if (pass_count !== 10'd99) begin n_bad++; $display("FAIL midrun_pre got %0d want 99", pass_count); end
    drive_vec(100, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if ({in_ready, done, all_pass, seq_err, ffv_valid} !== 5'b00000) begin n_bad++; $display("FAIL midrun_flags got %b want 00000", {in_ready, done, all_pass, seq_err, ffv_valid}); end
    n_cmp++; if (pass_count !== 10'd0 || fail_count !== 10'd0) begin n_bad++; $display("FAIL midrun_counts got %0d/%0d want 0/0", pass_count, fail_count); end
    tick();
    n_cmp++; if (pass_count !== 10'd0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL midrun_flush got pass=%0d ready=%b want 0/0", pass_count, in_ready); end
    pulse_start();
    for (int i = 0; i < 512; i++) begin
      drive_vec(i, 1'b0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (pass_count !== 10'd512 || all_pass !== 1'b1) begin n_bad++; $display("FAIL midrun_resweep got %0d/%b want 512/1", pass_count, all_pass); end
  endtask

  task automatic test_order();
    int v;
    do_reset();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = (i < 5) ? i : i + 1;
      drive_vec(v, 1'b0);
      in_valid16 = 1'b1;
      tick();
      if (i == 5) begin
        n_cmp++; if (seq_err16 !== 1'b0) begin n_bad++; $display("FAIL order_before got %b want 0", seq_err16); end
      end
      if (i == 6) begin
        n_cmp++; if (seq_err16 !== 1'b1) begin n_bad++; $display("FAIL order_set got %b want 1", seq_err16); end
      end
    end
    in_valid16 = 1'b0;
    tick();
    n_cmp++; if (done16 !== 1'b1 || all_pass16 !== 1'b0 || seq_err16 !== 1'b1) begin n_bad++; $display("FAIL order_done got done=%b all=%b seq=%b want 1/0/1", done16, all_pass16, seq_err16); end
    n_cmp++; if (pass_count16 !== 10'd16 || fail_count16 !== 10'd0) begin n_bad++; $display("FAIL order_counts got %0d/%0d want 16/0", pass_count16, fail_count16); end
  endtask

  task automatic test_restart();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n_cmp++; if (pass_count16 !== 10'd0 || fail_count16 !== 10'd0 || seq_err16 !== 1'b0) begin n_bad++; $display("FAIL restart_clear got %0d/%0d/%b want 0/0/0", pass_count16, fail_count16, seq_err16); end
    n_cmp++; if (done16 !== 1'b0 || in_ready16 !== 1'b1) begin n_bad++; $display("FAIL restart_state got done=%b ready=%b want 0/1", done16, in_ready16); end
    for (int i = 0; i < 16; i++) begin
      drive_vec(i, 1'b0);
      in_valid16 = 1'b1;
      start16 = (i == 8);
      tick();
    end
    start16 = 1'b0;
    in_valid16 = 1'b0;
    tick();
    n_cmp++; if (done16 !== 1'b1 || all_pass16 !== 1'b1) begin n_bad++; $display("FAIL restart_done got %b/%b want 1/1", done16, all_pass16); end
    n_cmp++; if (pass_count16 !== 10'd16 || ffv_valid16 !== 1'b0) begin n_bad++; $display("FAIL restart_counts got %0d/%b want 16/0", pass_count16, ffv_valid16); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_fault();
    test_gapped();
    test_reset_midrun();
    test_order();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
